// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle between a producer/consumer pair and sync_fifo_param.
// The FIFO uses the slave view. The client side uses the master view.
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             almost_full;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             empty;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, almost_full, rd_data, rd_valid, empty, almost_empty,
           count, overflow, underflow
  );

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, almost_full, rd_data, rd_valid, empty, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags, overflow/underflow pulses and a choice of
// registered or first-word-fall-through read.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  sync_fifo_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;

  // Flags come from the registered count only, so full and empty can never
  // be confused across pointer wrap and never depend on this cycle's requests.
  assign w_full   = (r_count == C_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = bus.wr_en & ~w_full;
  assign w_rd_acc = bus.rd_en & ~w_empty;

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= C_AF);
  assign bus.almost_empty = (r_count <= C_AE);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  // Storage write; contents are not reset, reset only blocks the write.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !rst) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.wr_data;
    end
  end

  // Pointers and occupancy; simultaneous accepts leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // One-cycle error pulses for requests made against the pre-edge flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= bus.wr_en & w_full;
      r_underflow <= bus.rd_en & w_empty;
    end
  end

  if (FWFT == 0) begin : g_reg_read
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    // Registered read: data captured on accept, valid for the next cycle only.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
  end else begin : g_fwft_read
    // Head word is presented directly; rd_en acknowledges it.
    assign bus.rd_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign bus.rd_valid = ~w_empty;
  end
endmodule
